// File: rtl/vram_rect_fill_pkg.sv
// Shared definitions for the mini-GPU fill path: framebuffer geometry, pixel type,
// fill FSM encoding and the shift-add row offset used instead of a multiplier.
package minigpu_pkg;

    localparam int FB_W_DEF = 320;
    localparam int FB_H_DEF = 240;

    typedef logic [7:0] rgb332_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_FILL   = 2'd2,
        ST_FINISH = 2'd3
    } fill_state_t;

    // y*320 == (y<<8) + (y<<6); the framebuffer width is fixed at 320
    function automatic logic [31:0] y_times_fb_w(input logic [7:0] y);
        return ({24'd0, y} << 8) + ({24'd0, y} << 6);
    endfunction

endpackage

// File: rtl/vram_rect_fill_if.sv
// Command, status and VRAM port-B signals of the rectangle fill engine.
interface vram_rect_fill_if
    import minigpu_pkg::*;
#(
    parameter int ADDR_W = 18
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic [8:0]        x0;
    logic [8:0]        x1;
    logic [7:0]        y0;
    logic [7:0]        y1;
    rgb332_t           color;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] vram_addr;
    rgb332_t           vram_data;
    logic              vram_we;

    modport slave (
        input  start, abort, base_addr, x0, x1, y0, y1, color,
        output busy, done, vram_addr, vram_data, vram_we
    );

    modport master (
        output start, abort, base_addr, x0, x1, y0, y1, color,
        input  busy, done, vram_addr, vram_data, vram_we
    );
endinterface

// File: rtl/vram_rect_fill_addr_gen.sv
// Row-major pixel walker: holds the address of the next pixel to write and flags
// when that pixel is the bottom-right corner. Loaded on command accept, advanced by i_step.
module rect_addr_gen
    import minigpu_pkg::*;
#(
    parameter int ADDR_W = 18,
    parameter int FB_W   = FB_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [8:0]        i_x0,
    input  logic [7:0]        i_y0,
    input  logic              i_step,
    input  logic [8:0]        i_x1c,
    input  logic [7:0]        i_y1c,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);
    logic [ADDR_W-1:0] r_row_addr;
    logic [8:0]        r_x0;
    logic [8:0]        r_cur_x;
    logic [7:0]        r_cur_y;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_row_addr <= '0;
            r_x0       <= '0;
            r_cur_x    <= '0;
            r_cur_y    <= '0;
        end else if (i_load) begin
            r_row_addr <= i_base + ADDR_W'(y_times_fb_w(i_y0));
            r_x0       <= i_x0;
            r_cur_x    <= i_x0;
            r_cur_y    <= i_y0;
        end else if (i_step) begin
            if (r_cur_x < i_x1c) begin
                r_cur_x <= r_cur_x + 9'd1;
            end else begin
                r_cur_x    <= r_x0;
                r_cur_y    <= r_cur_y + 8'd1;
                r_row_addr <= r_row_addr + ADDR_W'(FB_W);
            end
        end
    end

    assign o_addr = r_row_addr + ADDR_W'(r_cur_x);
    assign o_last = (r_cur_x == i_x1c) && (r_cur_y == i_y1c);

endmodule

// File: rtl/vram_rect_fill.sv
// Clipped solid-rectangle fill into VRAM port B, one byte per clock in row-major order.
// Registered outputs track the state: BUSY in SETUP/FILL, WE only in FILL, DONE in FINISH.
module vram_rect_fill
    import minigpu_pkg::*;
#(
    parameter int ADDR_W = 18,
    parameter int FB_W   = FB_W_DEF,
    parameter int FB_H   = FB_H_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    vram_rect_fill_if.slave  bus
);
    fill_state_t       r_state, w_next;
    logic [8:0]        r_x0, r_x1;
    logic [7:0]        r_y0, r_y1;
    rgb332_t           r_color;
    logic              r_busy, r_done, r_we, r_last;
    logic [ADDR_W-1:0] r_addr;
    rgb332_t           r_data;

    logic [8:0]        w_x1c;
    logic [7:0]        w_y1c;
    logic              w_empty, w_load, w_step, w_gen_last;
    logic [ADDR_W-1:0] w_gen_addr;

    assign w_x1c   = (r_x1 > 9'(FB_W - 1)) ? 9'(FB_W - 1) : r_x1;
    assign w_y1c   = (r_y1 > 8'(FB_H - 1)) ? 8'(FB_H - 1) : r_y1;
    assign w_empty = (r_x0 > w_x1c) || (r_y0 > w_y1c);
    assign w_load  = (r_state == ST_IDLE) && bus.start;

    rect_addr_gen #(.ADDR_W(ADDR_W), .FB_W(FB_W)) u_addr_gen (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_load),
        .i_base  (bus.base_addr),
        .i_x0    (bus.x0),
        .i_y0    (bus.y0),
        .i_step  (w_step),
        .i_x1c   (w_x1c),
        .i_y1c   (w_y1c),
        .o_addr  (w_gen_addr),
        .o_last  (w_gen_last)
    );

    // w_step registers the walker's pending pixel as the next write; r_last marks
    // that the write currently on the port is the final one.
    always_comb begin
        w_next = r_state;
        w_step = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) w_next = ST_SETUP;
            end
            ST_SETUP: begin
                if (bus.abort || w_empty) begin
                    w_next = ST_FINISH;
                end else begin
                    w_next = ST_FILL;
                    w_step = 1'b1;
                end
            end
            ST_FILL: begin
                if (bus.abort || r_last) w_next = ST_FINISH;
                else                     w_step = 1'b1;
            end
            ST_FINISH: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_x0    <= '0;
            r_x1    <= '0;
            r_y0    <= '0;
            r_y1    <= '0;
            r_color <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_we    <= 1'b0;
            r_last  <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_x0    <= bus.x0;
                r_x1    <= bus.x1;
                r_y0    <= bus.y0;
                r_y1    <= bus.y1;
                r_color <= bus.color;
            end
            r_busy <= (w_next == ST_SETUP) || (w_next == ST_FILL);
            r_done <= (w_next == ST_FINISH);
            r_we   <= w_step;
            if (w_step) begin
                r_addr <= w_gen_addr;
                r_data <= r_color;
                r_last <= w_gen_last;
            end
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.vram_we   = r_we;
    assign bus.vram_addr = r_addr;
    assign bus.vram_data = r_data;

endmodule

// File: doc/vram_rect_fill.md
# vram_rect_fill

Rectangle-fill engine that writes solid RGB332 color into the framebuffer through the VRAM write port (port B), upstream of the scanout path. It accepts one rectangle command at a time, clips it to the 320x240 framebuffer, and emits one byte write per clock in row-major order. It provides clear-screen and solid-rectangle primitives for the GPU command path.

## Interface
Parameters:
- ADDR_W, 18, VRAM port B address width
- FB_W, 320, framebuffer width in pixels (bytes per row)
- FB_H, 240, framebuffer height in rows

Ports:
- CLK  in  1  system clock; same clock as VRAM port B
- RST_N  in  1  asynchronous active-low reset
- START  in  1  command strobe; sampled only in IDLE
- ABORT  in  1  stop the current fill at the next edge
- BASE_ADDR  in  ADDR_W  framebuffer base byte address
- X0, X1  in  9 each  inclusive column bounds
- Y0, Y1  in  8 each  inclusive row bounds
- COLOR  in  8  RGB332 fill value
- BUSY  out  1  high from the cycle after an accepted START until DONE
- DONE  out  1  one-cycle pulse when the command completes or is aborted
- VRAM_ADDR  out  ADDR_W  to ADDR_B
- VRAM_DATA  out  8  to DATA_B
- VRAM_WE  out  1  to WE_B

## Operation
- States: IDLE, SETUP, FILL, FINISH.
- IDLE:
  - START=1 latches BASE_ADDR, X0/X1/Y0/Y1 and COLOR, then moves to SETUP.
  - Inputs are not sampled again until the next IDLE.
- SETUP:
  - Clip: X1c = min(X1, FB_W-1), Y1c = min(Y1, FB_H-1).
  - Empty rectangle: if X0 > X1c or Y0 > Y1c, go to FINISH with no writes.
  - Otherwise: row_addr = BASE_ADDR + Y0*FB_W, cur_x = X0, cur_y = Y0, then go to FILL.
  - Y0*FB_W is computed as (Y0<<8) + (Y0<<6). No multiplier.
- FILL, each cycle:
  - VRAM_WE=1, VRAM_ADDR = row_addr + cur_x, VRAM_DATA = latched COLOR.
  - If cur_x < X1c: cur_x++.
  - Otherwise: cur_x = X0, cur_y++, row_addr += FB_W.
  - After the write at (X1c, Y1c), go to FINISH.
- FINISH: DONE=1 for one cycle, then IDLE.
- ABORT:
  - In SETUP or FILL, the next state is FINISH.
  - Any write already driven in the ABORT cycle completes; no further writes follow.
  - In IDLE or FINISH, ABORT is ignored.
- Address arithmetic:
  - All address sums are modulo 2^ADDR_W. Wrap is silent.
  - The caller guarantees BASE_ADDR + FB_W*FB_H <= VRAM size.
- START while BUSY is ignored, not queued.
- START and ABORT together in IDLE: START is accepted and ABORT is ignored.

## Timing
- Reset values:
  - State = IDLE.
  - BUSY, DONE and VRAM_WE = 0.
  - VRAM_ADDR = 0, VRAM_DATA = 0.
- All outputs are registered.
- Cycle sequence for START at edge 0:
  - Edge 1: SETUP, BUSY=1.
  - Edge 2: first VRAM_WE=1.
  - One write per cycle thereafter, N = (X1c-X0+1)*(Y1c-Y0+1) writes.
  - DONE is high in the cycle after the last write; BUSY falls with it.
- Total command latency: N + 2 cycles to DONE; N = 0 gives DONE at edge 2.
- Back-to-back: a START in the DONE cycle is ignored. The earliest accepted START is one cycle after DONE.
- Reset mid-fill:
  - All outputs return to reset values asynchronously.
  - No partial write is asserted after RST_N falls.
- VRAM_WE is never high outside FILL.

## Structure
- Shared package minigpu_pkg holds:
  - FB_W and FB_H defaults.
  - RGB332 type (8 bits).
  - The fill state encoding (IDLE/SETUP/FILL/FINISH).
- One sub-module, rect_addr_gen: the row/column counters plus the row_addr accumulator, exposing a step input, the current address and a last flag.
- The FSM, clipping and output registers stay in vram_rect_fill.

## Test plan
- Full clear:
  - Stimulus: BASE=0, X0=0, X1=319, Y0=0, Y1=239, COLOR=8'hE0.
  - Response: 76800 writes at addresses 0..76799 in order, all 8'hE0. DONE at cycle 76802; BUSY high for 76801 cycles.
- Small rectangle:
  - Stimulus: BASE=0x100, X=10..12, Y=2..3.
  - Response: writes at 0x100+650, 651, 652, 970, 971, 972, in that order. DONE 8 cycles after START.
- Clipping and empty:
  - Stimulus 1: X=318..400, Y=239..250.
  - Response 1: exactly 2 writes, at 76798 and 76799.
  - Stimulus 2: X0=5, X1=4.
  - Response 2: zero writes, DONE at cycle 2.
- Abort:
  - Stimulus: assert ABORT in the 5th FILL cycle of a 100-pixel fill.
  - Response: exactly 5 writes, DONE next cycle, then IDLE.
  - Follow-up: a START issued while BUSY does nothing.
- Async reset:
  - Stimulus: drop RST_N mid-fill, between clock edges.
  - Response: VRAM_WE, BUSY and DONE go to 0 immediately.
  - Follow-up: after release, a new 1x1 fill writes BASE + Y0*320 + X0 at cycle 2.
